// File: rtl/jac1_mem_arbiter.sv
// Jac1 memory arbiter: shares one single-port memory between loader, data and fetch requesters.
// The loader has fixed priority; data and fetch alternate. Each access is a fixed-latency cycle.
module jac1_mem_arbiter #(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned AddrWidth  = 8,
  parameter int unsigned MemLatency = 1
) (
  input  logic                 clk,
  input  logic                 sys_res,
  input  logic                 ld_req,
  input  logic                 ld_we,
  input  logic [AddrWidth-1:0] ld_addr,
  input  logic [DataWidth-1:0] ld_wdata,
  output logic                 ld_ack,
  input  logic                 dt_req,
  input  logic                 dt_we,
  input  logic [AddrWidth-1:0] dt_addr,
  input  logic [DataWidth-1:0] dt_wdata,
  output logic                 dt_ack,
  input  logic                 fe_req,
  input  logic [AddrWidth-1:0] fe_addr,
  output logic                 fe_ack,
  output logic [DataWidth-1:0] rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 cpu_stall,
  output logic                 busy
);

  // A latency of 0 is promoted to 1 so the counter always has a valid terminal value.
  localparam int unsigned Lat  = (MemLatency == 0) ? 1 : MemLatency;
  localparam int unsigned CntW = (Lat > 1) ? $clog2(Lat) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {G_NONE, G_LD, G_DT, G_FE} grant_t;

  state_t              state, state_d;
  grant_t              grant, grant_d;
  logic [CntW-1:0]     cnt, cnt_d;
  logic                rr_last_dt, rr_last_dt_d;
  logic                mem_en_d, mem_we_d, busy_d;
  logic [AddrWidth-1:0] mem_addr_d;
  logic [DataWidth-1:0] mem_wdata_d, rdata_d;
  logic                ld_ack_d, dt_ack_d, fe_ack_d;
  logic                ack_any;

  // An ack still on the outputs means its requester has not yet dropped req; skip arbitration once.
  assign ack_any   = ld_ack | dt_ack | fe_ack;
  assign cpu_stall = ld_req || (grant == G_LD);

  // State and registered outputs
  always_ff @(posedge clk or posedge sys_res) begin
    if (sys_res) begin
      state      <= S_IDLE;
      grant      <= G_NONE;
      cnt        <= '0;
      rr_last_dt <= 1'b1;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      ld_ack     <= 1'b0;
      dt_ack     <= 1'b0;
      fe_ack     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      cnt        <= cnt_d;
      rr_last_dt <= rr_last_dt_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      rdata      <= rdata_d;
      ld_ack     <= ld_ack_d;
      dt_ack     <= dt_ack_d;
      fe_ack     <= fe_ack_d;
      busy       <= busy_d;
    end
  end

  // Next-state, arbitration and next-output logic
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    cnt_d        = cnt;
    rr_last_dt_d = rr_last_dt;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    rdata_d      = rdata;
    ld_ack_d     = 1'b0;
    dt_ack_d     = 1'b0;
    fe_ack_d     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!ack_any && (ld_req || dt_req || fe_req)) begin
          state_d = S_ACCESS;
          cnt_d   = CntW'(Lat - 1);
          if (ld_req) begin
            grant_d     = G_LD;
            mem_we_d    = ld_we;
            mem_addr_d  = ld_addr;
            mem_wdata_d = ld_wdata;
          end else if (dt_req && !(fe_req && rr_last_dt)) begin
            grant_d      = G_DT;
            rr_last_dt_d = 1'b1;
            mem_we_d     = dt_we;
            mem_addr_d   = dt_addr;
            mem_wdata_d  = dt_wdata;
          end else begin
            grant_d      = G_FE;
            rr_last_dt_d = 1'b0;
            mem_we_d     = 1'b0;
            mem_addr_d   = fe_addr;
            mem_wdata_d  = '0;
          end
        end
      end
      S_ACCESS: begin
        mem_en_d = 1'b1;
        if (cnt == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt - CntW'(1);
        end
      end
      S_RESP: begin
        mem_we_d = 1'b0;
        rdata_d  = mem_rdata;
        ld_ack_d = (grant == G_LD);
        dt_ack_d = (grant == G_DT);
        fe_ack_d = (grant == G_FE);
        grant_d  = G_NONE;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule
